letc_core_console_tx: RTL and testbench

- Synthesizable replacement for the simulation-only console print path: the core's store to the debug console address (0xFFFFFFFF) hands one byte per write to this block.
- Sits directly downstream of the core writeback/DMSS store commit.
- Buffers bytes in a small FIFO and serializes them on an 8N1 UART TX line, so FPGA builds can see program output.

---
 rtl/letc_core_pkg.sv | 25 ++
 rtl/letc_core_console_fifo.sv | 64 ++++++
 rtl/letc_core_console_tx.sv | 172 +++++++++++++++++
 tb/tb_letc_core_console_tx.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/letc_core_pkg.sv
// ---------------------------------------------------------------------------
// letc_core_pkg
// Shared types and constants for the LETC core console path.
//   console_state_e    : UART transmitter FSM states
//   CONSOLE_ADDR       : store address that the core routes to the console
//   CONSOLE_FRAME_BITS : 8N1 frame length in bit times (start + 8 data + stop)
//   ASCII_LF/ASCII_CR  : line-ending characters used by the optional CRLF
//                        expansion (LETC_CORE_CONSOLE_CRLF_EN)
// ---------------------------------------------------------------------------
package letc_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } console_state_e;

    localparam logic [31:0] CONSOLE_ADDR       = 32'hFFFFFFFF;
    localparam int          CONSOLE_FRAME_BITS = 10;

    localparam logic [7:0]  ASCII_LF = 8'h0A;
    localparam logic [7:0]  ASCII_CR = 8'h0D;

endpackage

// File: rtl/letc_core_console_fifo.sv
// ---------------------------------------------------------------------------
// letc_core_console_fifo
// Synchronous FIFO with a registered occupancy count.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (pointers/count)
//   push, push_data   : write request; ignored while full
//   pop               : read request; ignored while empty
//   pop_data          : head entry (valid while !empty)
//   full, empty       : derived from the registered count
//   count             : occupancy, 0..FIFO_DEPTH
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module letc_core_console_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             pop_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by the pointers above.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/letc_core_console_tx.sv
// ---------------------------------------------------------------------------
// letc_core_console_tx
// Console byte sink for the core's store to CONSOLE_ADDR: bytes are queued in
// a small FIFO and shifted out as 8N1 UART frames.
// Ports:
//   clk, rst_n    : core clock, asynchronous active-low reset
//   i_wr_valid    : byte write request (held by the core until accepted)
//   i_wr_data     : byte to print
//   o_wr_ready    : FIFO not full; accept = i_wr_valid & o_wr_ready at posedge
//   o_tx          : registered UART line, idle high
//   o_busy        : transmitter active or bytes still queued
//   o_fifo_count  : FIFO occupancy
// Build option:
//   LETC_CORE_CONSOLE_CRLF_EN - a popped 0x0A is sent as 0x0D followed by
//   0x0A (two frames, one FIFO pop).
// ---------------------------------------------------------------------------
module letc_core_console_tx
    import letc_core_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_wr_valid,
    input  logic [7:0]                    i_wr_data,
    output logic                          o_wr_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

    localparam int             BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    console_state_e state;
    logic [BW-1:0]  baud;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           baud_done;

    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [7:0]     fifo_data;

    logic           lf_pend;
    logic           load;
    logic [7:0]     load_byte;

    letc_core_console_fifo #(
        .DATA_W     (8),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (i_wr_valid),
        .push_data  (i_wr_data),
        .pop        (fifo_pop),
        .pop_data   (fifo_data),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (o_fifo_count)
    );

    assign o_wr_ready = ~fifo_full;
    assign o_busy     = (state != IDLE) | (o_fifo_count != '0);
    assign baud_done  = (baud == BAUD_LAST);

    // A new frame starts from IDLE as soon as a byte is queued, or back to
    // back at the end of STOP. A pending LF replay takes precedence over the
    // FIFO so the CR/LF pair stays together.
    always_comb begin
        fifo_pop = 1'b0;
        case (state)
            IDLE:    fifo_pop = ~fifo_empty;
            STOP:    fifo_pop = baud_done & ~lf_pend & ~fifo_empty;
            default: fifo_pop = 1'b0;
        endcase
    end

    assign load = fifo_pop | ((state == STOP) & baud_done & lf_pend);

`ifdef LETC_CORE_CONSOLE_CRLF_EN
    // A popped LF is first sent as CR; lf_pend remembers to send the LF next.
    assign load_byte = lf_pend                 ? ASCII_LF :
                       (fifo_data == ASCII_LF) ? ASCII_CR : fifo_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lf_pend <= 1'b0;
        end else if (load) begin
            lf_pend <= ~lf_pend & (fifo_data == ASCII_LF);
        end
    end
`else
    assign load_byte = fifo_data;
    assign lf_pend   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            o_tx    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= START;
                        baud  <= '0;
                        o_tx  <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        state   <= DATA;
                        baud    <= '0;
                        bit_idx <= '0;
                        o_tx    <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            o_tx  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            // shift[0] is the bit just sent; shift[1] is next.
                            o_tx    <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (load) begin
                            state <= START;
                            o_tx  <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    baud  <= '0;
                    o_tx  <= 1'b1;
                end
            endcase
        end
    end

    // Shift register holds data only; it is always reloaded before use.
    always_ff @(posedge clk) begin
        if (load) begin
            shift <= load_byte;
        end else if ((state == DATA) && baud_done) begin
            shift <= shift >> 1;
        end
    end

endmodule

// File: tb/tb_letc_core_console_tx.sv
// ---------------------------------------------------------------------------
// tb_letc_core_console_tx
// Self-checking bench for letc_core_console_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// A frame-level model (byte queue + cycle offset inside a 10-bit frame)
// predicts o_tx, o_wr_ready, o_busy and o_fifo_count every cycle; a UART
// decoder recovers the bytes from o_tx for end-to-end checks.
// Honors LETC_CORE_CONSOLE_CRLF_EN when defined for the build.
// ---------------------------------------------------------------------------
module tb_letc_core_console_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       o_wr_ready;
    logic       o_tx;
    logic       o_busy;
    logic [2:0] o_fifo_count;

    int total = 0;
    int bad   = 0;

    letc_core_console_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_wr_valid   (wr_valid),
        .i_wr_data    (wr_data),
        .o_wr_ready   (o_wr_ready),
        .o_tx         (o_tx),
        .o_busy       (o_busy),
        .o_fifo_count (o_fifo_count)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] mq[$];
    bit         m_act = 1'b0;
    int         m_off = 0;
    logic [7:0] m_cur = 8'h00;
    bit         m_lf  = 1'b0;
    bit         m_acc = 1'b0;
    bit         m_take;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_act = 1'b0;
            m_off = 0;
            m_lf  = 1'b0;
            m_acc = 1'b0;
        end else begin
            m_take = wr_valid && (mq.size() != DEPTH);
            if (m_act && m_off < FRAME - 1) begin
                m_off++;
            end else if (m_act && m_lf) begin
                m_cur = 8'h0A;
                m_lf  = 1'b0;
                m_off = 0;
            end else if (mq.size() != 0) begin
                m_cur = mq.pop_front();
                m_off = 0;
                m_act = 1'b1;
`ifdef LETC_CORE_CONSOLE_CRLF_EN
                if (m_cur == 8'h0A) begin
                    m_cur = 8'h0D;
                    m_lf  = 1'b1;
                end
`endif
            end else begin
                m_act = 1'b0;
            end
            if (m_take) mq.push_back(wr_data);
            m_acc = m_take;
        end
    end

    function automatic logic model_tx();
        logic [9:0] f;
        f = {1'b1, m_cur, 1'b0};
        return m_act ? f[m_off / CPB] : 1'b1;
    endfunction

    // ---------------- UART decoder ----------------
    logic [7:0] rx_q[$];
    int         rx_cnt = -1;
    logic [7:0] rx_sh = 8'h00;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (o_tx == 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if ((rx_cnt % CPB) == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8)
                rx_sh[rx_cnt / CPB - 1] = o_tx;
            if (rx_cnt == 9 * CPB + CPB / 2) begin
                rx_q.push_back(rx_sh);
                rx_cnt = -1;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("tx",       {31'd0, o_tx},        {31'd0, model_tx()});
            chk("wr_ready", {31'd0, o_wr_ready},  {31'd0, (mq.size() != DEPTH)});
            chk("busy",     {31'd0, o_busy},      {31'd0, (m_act || mq.size() != 0)});
            chk("count",    {29'd0, o_fifo_count}, 32'(mq.size()));
        end
    endtask

    // Drive a byte and hold it until the model says it was taken.
    task automatic send_byte(input logic [7:0] b);
        int n;
        wr_valid = 1'b1;
        wr_data  = b;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!m_acc && n < 2000);
        if (!m_acc) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: byte %0h not taken after %0d cycles", b, n);
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_act || mq.size() != 0) && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: line still active after %0d cycles", n);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] exp_q[$];
    logic [9:0] f41;
    int         base;
    int         gap;
    logic [7:0] b;

    initial begin
        fork
            compare_loop();
        join_none

        // 1. reset then idle
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("idle_tx",    {31'd0, o_tx},        32'd1);
        chk("idle_ready", {31'd0, o_wr_ready},  32'd1);
        chk("idle_busy",  {31'd0, o_busy},      32'd0);
        chk("idle_count", {29'd0, o_fifo_count}, 32'd0);

        // 2. single byte 0x41, waveform pinned by a hand-written frame
        f41  = 10'b1_01000001_0;
        base = rx_q.size();
        send_byte(8'h41);
        for (int k = 0; k <= 41; k++) begin
            @(negedge clk);
            if (k == 0)  chk("b41_pre", {31'd0, o_tx}, 32'd1);
            if (k >= 1 && k <= 40 && ((k - 1) % CPB) == 1)
                chk("b41_bit", {31'd0, o_tx}, {31'd0, f41[(k - 1) / CPB]});
            if (k == 40) chk("b41_busy_hi", {31'd0, o_busy}, 32'd1);
            if (k == 41) chk("b41_busy_lo", {31'd0, o_busy}, 32'd0);
        end
        wait_idle();
        chk("b41_rxn",  32'(rx_q.size() - base), 32'd1);
        chk("b41_byte", {24'd0, rx_q[base]}, 32'h41);

        // 3. back-to-back bytes
        base = rx_q.size();
        send_byte(8'h55);
        send_byte(8'hAA);
        wait_idle();
        chk("b2b_rxn", 32'(rx_q.size() - base), 32'd2);
        chk("b2b_0",   {24'd0, rx_q[base]},     32'h55);
        chk("b2b_1",   {24'd0, rx_q[base + 1]}, 32'hAA);

        // 4. fill the FIFO with the request held
        base = rx_q.size();
        for (int i = 0; i < 6; i++) begin
            send_byte(8'h30 + 8'(i));
            if (i == 4) begin
                chk("full_count", {29'd0, o_fifo_count}, 32'd4);
                chk("full_ready", {31'd0, o_wr_ready},  32'd0);
            end
        end
        wait_idle();
        chk("full_rxn", 32'(rx_q.size() - base), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("full_byte", {24'd0, rx_q[base + i]}, 32'h30 + 32'(i));

        // 5. reset mid-DATA with two bytes queued
        send_byte(8'h3C);
        send_byte(8'h11);
        send_byte(8'h22);
        repeat (14) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx",    {31'd0, o_tx},        32'd1);
        chk("rst_count", {29'd0, o_fifo_count}, 32'd0);
        chk("rst_busy",  {31'd0, o_busy},      32'd0);
        chk("rst_ready", {31'd0, o_wr_ready},  32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        base = rx_q.size();
        repeat (100) @(posedge clk);
        #1;
        chk("rst_no_frames", 32'(rx_q.size() - base), 32'd0);
        chk("rst_after_tx",  {31'd0, o_tx}, 32'd1);

        // 6. line feed
        base = rx_q.size();
        send_byte(8'h0A);
        wait_idle();
`ifdef LETC_CORE_CONSOLE_CRLF_EN
        chk("lf_rxn", 32'(rx_q.size() - base), 32'd2);
        chk("lf_cr",  {24'd0, rx_q[base]},     32'h0D);
        chk("lf_lf",  {24'd0, rx_q[base + 1]}, 32'h0A);
`else
        chk("lf_rxn", 32'(rx_q.size() - base), 32'd1);
        chk("lf_lf",  {24'd0, rx_q[base]},     32'h0A);
`endif

        // 7. randomized traffic
        base = rx_q.size();
        for (int i = 0; i < 60; i++) begin
            gap = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 60))
                                              : int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            b = ($urandom_range(0, 5) == 0) ? 8'h0A : 8'($urandom);
`ifdef LETC_CORE_CONSOLE_CRLF_EN
            if (b == 8'h0A) exp_q.push_back(8'h0D);
`endif
            exp_q.push_back(b);
            send_byte(b);
        end
        wait_idle();
        chk("rand_rxn", 32'(rx_q.size() - base), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < rx_q.size())
                chk("rand_byte", {24'd0, rx_q[base + i]}, {24'd0, exp_q[i]});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
